// File: rtl/button_debounce_toggle_pkg.sv
// Shared constants and types for the multi-channel button debouncer.
// The default window is 10 ms of the 12 MHz board clock.
package btn_pkg;
  localparam int CLK_HZ            = 12_000_000;
  localparam int DB_MS_DEFAULT     = 10;
  localparam int DB_CYCLES_DEFAULT = CLK_HZ / 1000 * DB_MS_DEFAULT;

  localparam bit MODE_TOGGLE = 1'b1;
  localparam bit MODE_LEVEL  = 1'b0;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic led;
  } ch_out_t;

  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction
endpackage

// File: rtl/button_debounce_toggle_if.sv
// Button bundle: raw active-low inputs in, debounced level/strobes/LED out.
interface button_debounce_toggle_if #(parameter int N_CH = 4) ();
  logic [N_CH-1:0] btn_n;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] led;

  modport master (output btn_n, input btn_level, press_pulse, release_pulse, led);
  modport slave  (input btn_n, output btn_level, press_pulse, release_pulse, led);
endinterface

// File: rtl/button_debounce_toggle_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, stable level,
// registered press/release strobes and LED drive.
module debounce_ch
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter bit TOGGLE    = MODE_TOGGLE
) (
  input  logic    hwclk,
  input  logic    rst,
  input  logic    btn_n_i,
  output ch_out_t out_o
);
  localparam int             CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          raw;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          led_q, led_d;

  assign raw = ~sync_q[1];

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_n_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      led_q    <= led_d;
    end
  end

  // Any sample matching the stable level restarts the window from zero.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (raw != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = raw;
      else                  cnt_d    = cnt_q + 1'b1;
    end
    press_d = ~stable_q & stable_d;
    rel_d   = stable_q & ~stable_d;
    led_d   = TOGGLE ? (led_q ^ press_d) : stable_d;
  end

  assign out_o = '{level: stable_q, press: press_q, rel: rel_q, led: led_q};
endmodule

// File: rtl/button_debounce_toggle.sv
// N_CH independent button debouncers on the 12 MHz board clock; buttons are
// only ever sampled as data, never used as clocks.
module button_debounce_toggle
  import btn_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter bit TOGGLE    = MODE_TOGGLE
) (
  input  logic                     hwclk,
  input  logic                     rst,
  button_debounce_toggle_if.slave  bus
);
  ch_out_t [N_CH-1:0] ch_o;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .TOGGLE    (TOGGLE)
    ) u_ch (
      .hwclk   (hwclk),
      .rst     (rst),
      .btn_n_i (bus.btn_n[i]),
      .out_o   (ch_o[i])
    );

    assign bus.btn_level[i]     = ch_o[i].level;
    assign bus.press_pulse[i]   = ch_o[i].press;
    assign bus.release_pulse[i] = ch_o[i].rel;
    assign bus.led[i]           = ch_o[i].led;
  end
endmodule

// File: tb/tb_button_debounce_toggle.sv
// Directed bench: expected strobes are queued with their due cycle when the
// stimulus is driven and popped when either DUT raises a strobe.
module tb_button_debounce_toggle;
  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
  } ev_t;

  logic hwclk = 1'b0;
  logic rst   = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  ev_t  q0[$];
  ev_t  q1[$];

  button_debounce_toggle_if #(.N_CH(4)) b0 ();
  button_debounce_toggle_if #(.N_CH(4)) b1 ();

  button_debounce_toggle #(.N_CH(4), .DB_CYCLES(8), .TOGGLE(1'b1)) dut0 (
    .hwclk (hwclk), .rst (rst), .bus (b0));
  button_debounce_toggle #(.N_CH(4), .DB_CYCLES(8), .TOGGLE(1'b0)) dut1 (
    .hwclk (hwclk), .rst (rst), .bus (b1));

  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic push0(input int dc, input logic [3:0] p, input logic [3:0] r);
    q0.push_back('{cyc + dc, p, r});
  endtask

  task automatic push1(input int dc, input logic [3:0] p, input logic [3:0] r);
    q1.push_back('{cyc + dc, p, r});
  endtask

  always @(negedge hwclk) begin : mon0
    ev_t e;
    if ((b0.press_pulse | b0.release_pulse) != 4'h0) begin
      if (q0.size() == 0)
        chk("dut0 unexpected strobe", {b0.press_pulse, b0.release_pulse}, 0);
      else begin
        e = q0.pop_front();
        chk("dut0 strobe cycle", cyc, e.cyc);
        chk("dut0 press_pulse", b0.press_pulse, e.p);
        chk("dut0 release_pulse", b0.release_pulse, e.r);
      end
    end
  end

  always @(negedge hwclk) begin : mon1
    ev_t e;
    if ((b1.press_pulse | b1.release_pulse) != 4'h0) begin
      if (q1.size() == 0)
        chk("dut1 unexpected strobe", {b1.press_pulse, b1.release_pulse}, 0);
      else begin
        e = q1.pop_front();
        chk("dut1 strobe cycle", cyc, e.cyc);
        chk("dut1 press_pulse", b1.press_pulse, e.p);
        chk("dut1 release_pulse", b1.release_pulse, e.r);
      end
    end
    if (!rst) chk("dut1 led tracks level", b1.led, b1.btn_level);
  end

  initial begin
    b0.btn_n = 4'h0;
    b1.btn_n = 4'hF;
    #1 rst = 1'b1;

    // 1: buttons held through reset
    step(3);
    chk("rst level", b0.btn_level, 4'h0);
    chk("rst press", b0.press_pulse, 4'h0);
    chk("rst release", b0.release_pulse, 4'h0);
    chk("rst led", b0.led, 4'h0);
    rst = 1'b0;
    push0(10, 4'hF, 4'h0);
    step(11);
    chk("post-rst level", b0.btn_level, 4'hF);
    chk("post-rst led", b0.led, 4'hF);
    b0.btn_n = 4'hF;
    push0(10, 4'h0, 4'hF);
    step(12);
    chk("all released level", b0.btn_level, 4'h0);
    chk("release keeps led", b0.led, 4'hF);

    // 2: clean presses on ch0
    b0.btn_n[0] = 1'b0;
    push0(10, 4'h1, 4'h0);
    step(12);
    chk("ch0 press level", b0.btn_level, 4'h1);
    chk("ch0 press led", b0.led, 4'hE);
    b0.btn_n[0] = 1'b1;
    push0(10, 4'h0, 4'h1);
    step(12);
    chk("ch0 release level", b0.btn_level, 4'h0);
    chk("ch0 release led", b0.led, 4'hE);
    b0.btn_n[0] = 1'b0;
    push0(10, 4'h1, 4'h0);
    step(12);
    chk("ch0 second press led", b0.led, 4'hF);
    b0.btn_n[0] = 1'b1;
    push0(10, 4'h0, 4'h1);
    step(12);

    // 3: bounce on ch1, then an 8-cycle press that must be accepted
    b0.btn_n[1] = 1'b0; step(7);
    b0.btn_n[1] = 1'b1; step(1);
    b0.btn_n[1] = 1'b0; step(7);
    b0.btn_n[1] = 1'b1; step(12);
    chk("bounce level", b0.btn_level, 4'h0);
    chk("bounce led", b0.led, 4'hF);
    b0.btn_n[1] = 1'b0;
    push0(10, 4'h2, 4'h0);
    push0(18, 4'h0, 4'h2);
    step(8);
    b0.btn_n[1] = 1'b1;
    step(14);
    chk("8-cycle press led", b0.led, 4'hD);

    // 4: ch2 and ch3 together
    b0.btn_n[3:2] = 2'b00;
    push0(10, 4'hC, 4'h0);
    step(12);
    chk("dual press level", b0.btn_level, 4'hC);
    chk("dual press led", b0.led, 4'h1);
    b0.btn_n[3:2] = 2'b11;
    push0(10, 4'h0, 4'hC);
    step(12);

    // 5: reset part-way through a press window
    b0.btn_n[0] = 1'b0;
    step(6);
    rst = 1'b1;
    #1;
    chk("mid rst level", b0.btn_level, 4'h0);
    chk("mid rst led", b0.led, 4'h0);
    step(2);
    rst = 1'b0;
    push0(10, 4'h1, 4'h0);
    step(11);
    chk("redetect level", b0.btn_level, 4'h1);
    chk("redetect led", b0.led, 4'h1);
    b0.btn_n[0] = 1'b1;
    push0(10, 4'h0, 4'h1);
    step(12);

    // 6: level-follow LED mode
    b1.btn_n[0] = 1'b0;
    push1(10, 4'h1, 4'h0);
    step(12);
    chk("lvl-mode level", b1.btn_level, 4'h1);
    chk("lvl-mode led", b1.led, 4'h1);
    b1.btn_n[0] = 1'b1;
    push1(10, 4'h0, 4'h1);
    step(12);
    chk("lvl-mode release led", b1.led, 4'h0);

    chk("dut0 strobes outstanding", q0.size(), 0);
    chk("dut1 strobes outstanding", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
